// File: rtl/pin_entry_pkg.sv
// pin_entry_pkg: shared types and constants for the keypad PIN entry block.
//   pin_state_t : entry FSM states
//   KEY_CLEAR   : keypad code that discards the partial PIN
//   KEY_ENTER   : keypad code that submits the PIN
//   is_digit()  : true for BCD digit codes 0x0-0x9
package pin_entry_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_D1    = 2'd1,
        WAIT_D2    = 2'd2,
        WAIT_ENTER = 2'd3
    } pin_state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/pin_timeout_counter.sv
// pin_timeout_counter: idle-cycle counter used to expire a partial PIN.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : force the count to zero (has priority over enable)
//   enable     : count one idle cycle
//   expired    : count has reached TIMEOUT_CYCLES-1; the next enabled
//                cycle is the expiry cycle
module pin_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            // Wrap on expiry; the owner leaves the counting states anyway.
            cnt <= expired ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pin_keypad_entry.sv
// pin_keypad_entry: turns keypad presses into a two-digit BCD PIN word and
// a one-cycle submit strobe for the gate controller.
//   clk, reset      : clock, asynchronous active-high reset
//   sensor_entrance : vehicle present; key entry is armed only while high
//   key_valid       : key_code is valid this cycle
//   key_code        : 0-9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF ignored
//   input_password  : last submitted PIN (high nibble typed first)
//   password_valid  : one-cycle pulse when input_password is updated
//   entry_error     : one-cycle pulse on ENTER with fewer than two digits
//   entry_active    : high in every state except IDLE
//   entry_timeout   : one-cycle pulse when a partial PIN expires
// Build option: define PIN_TIMEOUT_EN to expire partial PINs after
// TIMEOUT_CYCLES idle cycles; otherwise entry_timeout stays 0.
module pin_keypad_entry
    import pin_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_entrance,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] input_password,
    output logic       password_valid,
    output logic       entry_error,
    output logic       entry_active,
    output logic       entry_timeout
);

    if (TIMEOUT_CYCLES < 2 || CNT_W < $clog2(TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("pin_keypad_entry: counter too narrow for TIMEOUT_CYCLES");
    end

    pin_state_t state;
    logic [7:0] buffer;
    logic       timeout_fire;

    wire is_clear = key_valid && (key_code == KEY_CLEAR);
    wire is_enter = key_valid && (key_code == KEY_ENTER);
    wire is_dig   = key_valid && is_digit(key_code);

`ifdef PIN_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_expired;

    // Count only idle cycles while a partial/complete PIN is pending.
    assign tmo_clear = key_valid || !sensor_entrance ||
                       !(state == WAIT_D2 || state == WAIT_ENTER);

    pin_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmo_clear),
        .enable (!tmo_clear),
        .expired(tmo_expired)
    );

    // A key in the expiry cycle clears the counter, so it wins.
    assign timeout_fire = !tmo_clear && tmo_expired;
`else
    assign timeout_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            buffer         <= 8'h00;
            input_password <= 8'h00;
            password_valid <= 1'b0;
            entry_error    <= 1'b0;
            entry_active   <= 1'b0;
            entry_timeout  <= 1'b0;
        end else begin
            password_valid <= 1'b0;
            entry_error    <= 1'b0;
            entry_timeout  <= 1'b0;

            // Vehicle gone: drop everything, ahead of any same-cycle key.
            if (state != IDLE && !sensor_entrance) begin
                state        <= IDLE;
                buffer       <= 8'h00;
                entry_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sensor_entrance) begin
                            state        <= WAIT_D1;
                            entry_active <= 1'b1;
                        end
                    end
                    WAIT_D1: begin
                        if (is_dig) begin
                            buffer <= {key_code, 4'h0};
                            state  <= WAIT_D2;
                        end else if (is_enter) begin
                            entry_error <= 1'b1;
                        end
                    end
                    WAIT_D2: begin
                        if (is_dig) begin
                            buffer[3:0] <= key_code;
                            state       <= WAIT_ENTER;
                        end else if (is_clear) begin
                            buffer <= 8'h00;
                            state  <= WAIT_D1;
                        end else if (is_enter) begin
                            entry_error <= 1'b1;
                        end else if (timeout_fire) begin
                            buffer        <= 8'h00;
                            state         <= WAIT_D1;
                            entry_timeout <= 1'b1;
                        end
                    end
                    WAIT_ENTER: begin
                        // Extra digits fall through: the first two win.
                        if (is_enter) begin
                            input_password <= buffer;
                            password_valid <= 1'b1;
                            buffer         <= 8'h00;
                            state          <= WAIT_D1;
                        end else if (is_clear) begin
                            buffer <= 8'h00;
                            state  <= WAIT_D1;
                        end else if (timeout_fire) begin
                            buffer        <= 8'h00;
                            state         <= WAIT_D1;
                            entry_timeout <= 1'b1;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        buffer       <= 8'h00;
                        entry_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pin_keypad_entry.sv
// tb_pin_keypad_entry: table-driven check of pin_keypad_entry. Each vector
// drives one cycle of inputs and names the outputs expected right after
// the following rising edge. Timeout vectors depend on PIN_TIMEOUT_EN.
module tb_pin_keypad_entry;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_entrance;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] input_password;
    logic       password_valid;
    logic       entry_error;
    logic       entry_active;
    logic       entry_timeout;

    pin_keypad_entry #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sensor_entrance(sensor_entrance),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .input_password (input_password),
        .password_valid (password_valid),
        .entry_error    (entry_error),
        .entry_active   (entry_active),
        .entry_timeout  (entry_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       kv;
        logic [3:0] kc;
        logic [7:0] pw;
        logic       pv;
        logic       err;
        logic       act;
        logic       tmo;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_vec  = 0;

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s vec %0d: got %h, want %h", nm, idx, got, want);
    endtask

    task automatic add(input logic s, input logic kv, input logic [3:0] kc,
                       input logic [7:0] pw, input logic pv, input logic err,
                       input logic act, input logic tmo);
        vec_t v;
        v.s = s; v.kv = kv; v.kc = kc; v.pw = pw;
        v.pv = pv; v.err = err; v.act = act; v.tmo = tmo;
        vq.push_back(v);
    endtask

    // Idle cycles with sensor high, no key.
    task automatic idle(input int n, input logic [7:0] pw);
        for (int i = 0; i < n; i++) add(1, 0, 4'h0, pw, 0, 0, 1, 0);
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic run;
        foreach (vq[i]) begin
            sensor_entrance = vq[i].s;
            key_valid       = vq[i].kv;
            key_code        = vq[i].kc;
            @(posedge clk);
            @(negedge clk);
            chk("input_password", n_vec, input_password, vq[i].pw);
            chk("password_valid", n_vec, {7'h0, password_valid}, {7'h0, vq[i].pv});
            chk("entry_error",    n_vec, {7'h0, entry_error},    {7'h0, vq[i].err});
            chk("entry_active",   n_vec, {7'h0, entry_active},   {7'h0, vq[i].act});
            chk("entry_timeout",  n_vec, {7'h0, entry_timeout},  {7'h0, vq[i].tmo});
            n_vec++;
        end
        vq.delete();
        key_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " input_password"}, -1, input_password, 8'h00);
        chk({tag, " password_valid"}, -1, {7'h0, password_valid}, 8'h00);
        chk({tag, " entry_error"},    -1, {7'h0, entry_error},    8'h00);
        chk({tag, " entry_active"},   -1, {7'h0, entry_active},   8'h00);
        chk({tag, " entry_timeout"},  -1, {7'h0, entry_timeout},  8'h00);
    endtask

    initial begin
        reset = 1'b1; sensor_entrance = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        //   s  kv kc     pw     pv err act tmo
        add(0, 1, 4'h4, 8'h00, 0, 0, 0, 0);   // IDLE ignores keys
        add(1, 0, 4'h0, 8'h00, 0, 0, 1, 0);   // armed
        add(1, 1, 4'h4, 8'h00, 0, 0, 1, 0);
        add(1, 1, 4'hB, 8'h00, 0, 1, 1, 0);   // ENTER with one digit
        add(1, 0, 4'h0, 8'h00, 0, 0, 1, 0);
        add(1, 1, 4'h9, 8'h00, 0, 0, 1, 0);
        add(1, 1, 4'hB, 8'h49, 1, 0, 1, 0);
        add(1, 1, 4'h2, 8'h49, 0, 0, 1, 0);   // back-to-back keys
        add(1, 1, 4'h5, 8'h49, 0, 0, 1, 0);
        add(1, 1, 4'hB, 8'h25, 1, 0, 1, 0);
        add(1, 1, 4'h1, 8'h25, 0, 0, 1, 0);   // 1 7 CLEAR 4 9 ENTER
        add(1, 1, 4'h7, 8'h25, 0, 0, 1, 0);
        add(1, 1, 4'hA, 8'h25, 0, 0, 1, 0);
        add(1, 1, 4'h4, 8'h25, 0, 0, 1, 0);
        add(1, 1, 4'h9, 8'h25, 0, 0, 1, 0);
        add(1, 1, 4'hB, 8'h49, 1, 0, 1, 0);
        add(1, 1, 4'hE, 8'h49, 0, 0, 1, 0);   // reserved in WAIT_D1
        add(1, 1, 4'h3, 8'h49, 0, 0, 1, 0);
        add(1, 1, 4'hE, 8'h49, 0, 0, 1, 0);   // reserved in WAIT_D2
        add(1, 1, 4'h6, 8'h49, 0, 0, 1, 0);
        add(1, 1, 4'h5, 8'h49, 0, 0, 1, 0);   // third digit ignored
        add(1, 1, 4'hF, 8'h49, 0, 0, 1, 0);
        add(1, 1, 4'hB, 8'h36, 1, 0, 1, 0);
        add(1, 1, 4'hA, 8'h36, 0, 0, 1, 0);   // CLEAR in WAIT_D1
        add(1, 1, 4'hB, 8'h36, 0, 1, 1, 0);   // ENTER in WAIT_D1
        add(1, 1, 4'h4, 8'h36, 0, 0, 1, 0);
        add(1, 1, 4'h9, 8'h36, 0, 0, 1, 0);
        add(0, 1, 4'hB, 8'h36, 0, 0, 0, 0);   // sensor drop beats ENTER
        add(0, 0, 4'h0, 8'h36, 0, 0, 0, 0);
        add(1, 0, 4'h0, 8'h36, 0, 0, 1, 0);
        add(1, 1, 4'hB, 8'h36, 0, 1, 1, 0);   // buffer was discarded
        add(1, 1, 4'h7, 8'h36, 0, 0, 1, 0);
        add(1, 1, 4'h8, 8'h36, 0, 0, 1, 0);
        add(1, 1, 4'hB, 8'h78, 1, 0, 1, 0);
        run();

        // Asynchronous reset mid-cycle while password_valid is high.
        #2 reset = 1'b1;
        #1 chk_zero("async reset");
        @(negedge clk);
        reset = 1'b0;

        add(1, 0, 4'h0, 8'h00, 0, 0, 1, 0);
        add(1, 1, 4'h4, 8'h00, 0, 0, 1, 0);
`ifdef PIN_TIMEOUT_EN
        idle(7, 8'h00);
        add(1, 0, 4'h0, 8'h00, 0, 0, 1, 1);   // 8th idle cycle expires
        add(1, 0, 4'h0, 8'h00, 0, 0, 1, 0);
        add(1, 1, 4'h9, 8'h00, 0, 0, 1, 0);
        add(1, 1, 4'h1, 8'h00, 0, 0, 1, 0);
        add(1, 1, 4'hB, 8'h91, 1, 0, 1, 0);
        add(1, 1, 4'h4, 8'h91, 0, 0, 1, 0);
        idle(7, 8'h91);
        add(1, 1, 4'h5, 8'h91, 0, 0, 1, 0);   // key in expiry cycle wins
        add(1, 1, 4'hB, 8'h45, 1, 0, 1, 0);
`else
        idle(12, 8'h00);                       // partial PIN persists
        add(1, 1, 4'h9, 8'h00, 0, 0, 1, 0);
        add(1, 1, 4'hB, 8'h49, 1, 0, 1, 0);
`endif
        run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pin_keypad_entry.md
Name: pin_keypad_entry

Overview:
- Upstream stage of the parking gate controller; it turns keypad key presses into the 8-bit `input_password` word and a one-cycle submit strobe.
- A PIN is two BCD digits: the high nibble is typed first. For example, keys 4, 9, ENTER produce 8'b0100_1001.
- Key entry is armed only while `sensor_entrance` is high, so keys pressed with no vehicle present are ignored.
- It sits between the keypad scanner and the gate controller's `input_password` input.

Parameters:
- TIMEOUT_CYCLES, 200, idle cycles allowed between keys before a partial PIN is discarded (used only with PIN_TIMEOUT_EN).
- CNT_W, $clog2(TIMEOUT_CYCLES), width of the timeout counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sensor_entrance  input  1  vehicle present at entrance; enables key entry.
- key_valid  input  1  one-cycle strobe: key_code is valid this cycle.
- key_code  input  4  0x0-0x9 digit; 0xA CLEAR; 0xB ENTER; 0xC-0xF reserved, ignored.
- input_password  output  8  last submitted PIN; held until the next submission.
- password_valid  output  1  one-cycle pulse when input_password is updated.
- entry_error  output  1  one-cycle pulse when ENTER is pressed with fewer than 2 digits.
- entry_active  output  1  high in every state except IDLE.
- entry_timeout  output  1  one-cycle pulse when a partial PIN expires (0 without the macro).

Behaviour:
- Reset (asynchronous, immediate, any state): state=IDLE, digit buffer=8'h00, input_password=8'h00; password_valid, entry_error and entry_timeout low; timeout counter=0.
- Every output is a register; no output is combinational from the inputs.
- States:
  - IDLE: all keys ignored. sensor_entrance=1 -> WAIT_D1.
  - WAIT_D1: digit -> buffer[7:4]=digit, buffer[3:0]=0, go to WAIT_D2. CLEAR -> stay. ENTER -> entry_error pulse, stay.
  - WAIT_D2: digit -> buffer[3:0]=digit, go to WAIT_ENTER. CLEAR -> buffer=0, go to WAIT_D1. ENTER -> entry_error pulse, stay.
  - WAIT_ENTER:
    - ENTER -> input_password<=buffer, password_valid pulse, buffer=0, go to WAIT_D1 (the gate controller may demand a retry).
    - CLEAR -> buffer=0, go to WAIT_D1.
    - Further digits are ignored; the first two digits win.
- Latency: a key sampled at edge N updates state at edge N; the pulse outputs are high for exactly the cycle after edge N.
- sensor_entrance=0 in any non-IDLE state -> IDLE and buffer=0. This has priority over a same-cycle key_valid, and no password_valid is produced.
- key_valid with a reserved code: no effect, no error.
- input_password is never cleared except by reset; it holds the last submitted value across IDLE.
- Back-to-back key_valid on consecutive cycles are each processed.

Optional Feature:
- Macro: PIN_TIMEOUT_EN.
- Defined:
  - The counter increments each cycle in WAIT_D2 or WAIT_ENTER with no key_valid.
  - Any key_valid, or any other state, resets the counter to 0.
  - When the count reaches TIMEOUT_CYCLES-1: buffer=0, go to WAIT_D1, one-cycle entry_timeout pulse.
  - A key arriving in the expiry cycle wins and the timeout does not fire.
- Undefined: no counter is built; entry_timeout is tied to 0; partial PINs persist until CLEAR, ENTER or sensor drop.

Decomposition:
- Package pin_entry_pkg holds:
  - the state enum typedef (IDLE, WAIT_D1, WAIT_D2, WAIT_ENTER);
  - key constants KEY_CLEAR=4'hA and KEY_ENTER=4'hB;
  - the function is_digit(code).
- Sub-module pin_timeout_counter (CNT_W-bit, inputs clear and enable, output expired). It is instantiated only under PIN_TIMEOUT_EN.

Test Plan:
- Reset, then sensor_entrance=1 and keys 4, 9, ENTER -> input_password=8'h49; password_valid high for exactly 1 cycle after ENTER; entry_active=1.
- Keys 1, 7, CLEAR, 4, 9, ENTER -> one pulse only, input_password=8'h49; no pulse for 0x17.
- Keys 4, ENTER -> entry_error pulses once; input_password unchanged (8'h00 after reset); state still accepts 9, ENTER -> 8'h49.
- Keys 4, 9, 5, ENTER -> input_password=8'h49; key 0xE mid-entry ignored.
- Keys 4, 9, then sensor_entrance=0 in the same cycle as ENTER -> no password_valid; entry_active=0; input_password retains its old value. Asserting reset mid-entry clears all outputs asynchronously.
- PIN_TIMEOUT_EN, TIMEOUT_CYCLES=8: key 4 then 8 idle cycles -> entry_timeout pulse, back in WAIT_D1. Then 9, 1, ENTER -> 8'h91.
